// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer and its helpers.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT,
    FETCH,
    EXEC,
    HALTED,
    FAULT
  } state_e;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : pc_seq_pkg

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: branch target or sequential PC, plus alignment check.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  // Sequential increment is modulo 2^32, so the top word wraps to zero.
  assign next_pc_o    = br_taken_i ? br_target_i : (pc_i + INSTR_BYTES);
  assign misaligned_o = |next_pc_o[1:0];

endmodule : pc_next_calc

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches over req/ack, hands the word to execute,
// then advances the PC from the branch result, halting or faulting when told.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] retired_q, retired_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] next_pc;
  logic        next_misaligned;

  pc_next_calc u_next (
    .pc_i        (pc_q),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .next_pc_o   (next_pc),
    .misaligned_o(next_misaligned)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    fault_d    = fault_q;

    unique case (state_q)
      RESET_WAIT: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + 32'd1;
          // Halt wins over any branch result; PC stays on the halting instruction.
          if (halt_req) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else if (next_misaligned) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALTED, FAULT: state_d = state_q;
      default:       state_d = RESET_WAIT;
    endcase

    // Handshake outputs are registered from the state being entered.
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == EXEC);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q       <= RESET_WAIT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      retired_q     <= '0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      retired_q     <= retired_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, wait states,
// halt, misalignment fault, PC wrap and reset during a fetch.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        exec_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_retired = 32'd0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .exec_done  (exec_done),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt_req   (halt_req),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch of one word at exp_pc, then exec_done with the given branch result.
  task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] word,
                           input logic taken, input logic [31:0] target,
                           input logic [31:0] exp_next);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_req_low", {31'd0, imem_req}, 32'd0);
    check("exec_instr", instr, word);
    check("exec_instr_pc", instr_pc, exp_pc);
    exec_done = 1'b1;
    br_taken  = taken;
    br_target = target;
    step();
    exec_done = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    exp_retired = exp_retired + 32'd1;
    check("retired", retired, exp_retired);
    check("next_req", {31'd0, imem_req}, 32'd1);
    check("next_addr", imem_addr, exp_next);
    check("next_valid_low", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exec_done  = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    halt_req   = 1'b0;
    step();
    step();

    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_retired", retired, 32'h0);

    // Ack during RESET_WAIT must be ignored.
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    step();
    imem_ack   = 1'b0;
    check("rw_ack_ignored_valid", {31'd0, instr_valid}, 32'd0);
    check("rw_instr_unchanged", instr, 32'h0);

    // Sequential flow 0, 4, 8, 12.
    run_instr(32'h0, 32'hA000_0000, 1'b0, 32'h0, 32'h4);
    run_instr(32'h4, 32'hA000_0004, 1'b0, 32'h0, 32'h8);
    run_instr(32'h8, 32'hA000_0008, 1'b0, 32'h0, 32'hC);
    run_instr(32'hC, 32'hA000_000C, 1'b0, 32'h0, 32'h10);
    check("retired_four", retired, 32'd4);

    // Back to 8, then taken branch at 8 to 0x40.
    run_instr(32'h10, 32'hB000_0010, 1'b1, 32'h8, 32'h8);
    run_instr(32'h8, 32'hB000_0008, 1'b1, 32'h40, 32'h40);

    // Three wait cycles with stray exec inputs that must be ignored.
    exec_done = 1'b1;
    halt_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h40);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    exec_done = 1'b0;
    halt_req  = 1'b0;
    check("wait_retired", retired, exp_retired);
    check("wait_halted", {31'd0, halted}, 32'd0);
    run_instr(32'h40, 32'hC0DE_0040, 1'b0, 32'h0, 32'h44);

    // Wrap of sequential PC through the top word.
    run_instr(32'h44, 32'hC0DE_0044, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run_instr(32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b0, 32'h0, 32'h0);

    // Reset while a fetch is outstanding.
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_retired = 32'd0;
    check("midfetch_req", {31'd0, imem_req}, 32'd0);
    check("midfetch_addr", imem_addr, 32'h0);
    check("midfetch_retired", retired, 32'h0);
    check("midfetch_instr", instr, 32'h0);
    step();
    check("after_rw_req", {31'd0, imem_req}, 32'd1);

    // Halt beats a taken branch.
    check("halt_fetch_addr", imem_addr, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0073;
    step();
    imem_ack   = 1'b0;
    exec_done  = 1'b1;
    halt_req   = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h100;
    step();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_instr_pc", instr_pc, 32'h0);
    check("halt_addr", imem_addr, 32'h0);
    check("halt_req_low", {31'd0, imem_req}, 32'd0);
    check("halt_valid_low", {31'd0, instr_valid}, 32'd0);
    check("halt_retired", retired, 32'd1);
    // Stray exec_done and ack in HALTED.
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_5555;
    step();
    step();
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    halt_req  = 1'b0;
    br_taken  = 1'b0;
    check("halt_stray_retired", retired, 32'd1);
    check("halt_stray_req", {31'd0, imem_req}, 32'd0);
    check("halt_stray_instr", instr, 32'h0000_0073);
    check("halt_stray_sticky", {31'd0, halted}, 32'd1);
    check("halt_stray_addr", imem_addr, 32'h0);

    // Misaligned branch target faults.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clears_halt", {31'd0, halted}, 32'd0);
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_006F;
    step();
    imem_ack   = 1'b0;
    exec_done  = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h102;
    step();
    exec_done  = 1'b0;
    br_taken   = 1'b0;
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_addr", imem_addr, 32'h0);
    check("fault_req", {31'd0, imem_req}, 32'd0);
    check("fault_halted", {31'd0, halted}, 32'd0);
    check("fault_retired", retired, 32'd1);
    step();
    step();
    check("fault_sticky", {31'd0, fault}, 32'd1);
    check("fault_req_hold", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("fault_rst_clear", {31'd0, fault}, 32'd0);
    check("fault_rst_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-step program-counter sequencer for the processor core. Owns the architectural PC and fetches each instruction from instruction memory over a req/ack handshake. It presents the instruction to the execute datapath, then selects the next PC from the branch unit's taken/target result. It also tracks halt and misalignment faults and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals current PC.
- imem_ack  input  1  memory has returned imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/instr_pc valid for the datapath.
- instr  output  32  latched instruction word.
- instr_pc  output  32  PC of the latched instruction.
- exec_done  input  1  datapath finished the current instruction; branch inputs valid this cycle.
- br_taken  input  1  branch unit next-PC select (1 = take br_target).
- br_target  input  32  branch/jump target address.
- halt_req  input  1  current instruction is ecall/ebreak; stop after it.
- halted  output  1  sticky halt status.
- fault  output  1  sticky misaligned-next-PC fault.
- retired  output  32  count of completed instructions.

## Operation
- States: RESET_WAIT, FETCH, EXEC, HALTED, FAULT.
- RESET_WAIT: one cycle after reset deasserts; outputs idle; go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata into instr, pc into instr_pc, and go to EXEC.
- EXEC: instr_valid=1, imem_req=0. Wait for exec_done. When exec_done=1:
  - retired += 1.
  - If halt_req: go to HALTED. PC is unchanged, so it still points at the halting instruction. br_taken is ignored.
  - Otherwise next = br_taken ? br_target : pc + 4.
  - If next[1:0] != 0: go to FAULT; PC is unchanged.
  - Otherwise pc <= next and go to FETCH.
- HALTED and FAULT are terminal until rst. All outputs hold their values; imem_req=0 and instr_valid=0.
- Width rules:
  - pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - retired wraps from 32'hFFFF_FFFF to 0.
- Ignored inputs:
  - imem_ack outside FETCH.
  - exec_done, br_taken, br_target and halt_req outside EXEC.

## Timing
- Reset values: pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; halted=0; fault=0; retired=0; state=RESET_WAIT.
- rst has priority over every other input in every state. A request in flight when rst asserts is abandoned; imem_req is 0 in the cycle after the rst edge.
- imem_req and imem_addr are registered and stay stable until the ack edge. An ack arriving in the same cycle that req first rises is accepted, giving a minimum fetch of 1 cycle.
- Fetch-to-valid: instr_valid rises the cycle after the imem_ack edge.
- After exec_done, imem_req rises the next cycle at the new PC.
- Minimum throughput is 1 instruction per 2 cycles (FETCH + EXEC), with zero-wait memory and exec_done asserted in the first EXEC cycle.
- halted and fault rise the cycle after the qualifying exec_done and never fall before rst.

## Structure
- Shared package pc_seq_pkg contains:
  - the state enum (RESET_WAIT, FETCH, EXEC, HALTED, FAULT);
  - constant INSTR_BYTES = 4;
  - the default RESET_PC value.
- One sub-module, pc_next_calc, is combinational. Inputs: pc, br_taken, br_target. Outputs: next_pc and misaligned. It is reused by the verification model.
- The top level holds the FSM, the PC/instr/retired registers, and the sticky flags.

## Test plan
- Sequential flow: rst, then zero-wait acks and exec_done with br_taken=0 → imem_addr goes 0, 4, 8, 12; retired=4 after four exec_done pulses.
- Taken branch: at pc=8, exec_done with br_taken=1, br_target=32'h40 → next imem_addr=32'h40; retired increments by 1.
- Memory wait states: hold imem_ack low 3 cycles in FETCH → imem_req and imem_addr stay stable; instr_valid=0 until the cycle after ack; instr equals the acked imem_rdata.
- Halt beats branch: exec_done with halt_req=1 and br_taken=1, br_target=32'h100 → halted=1; instr_pc unchanged; no further imem_req; stray exec_done and imem_ack have no effect.
- Misaligned target: br_taken=1, br_target=32'h102 → fault=1; pc unchanged; imem_req stays 0. Then rst → imem_addr=RESET_PC and fault=0.
- Wrap and reset mid-fetch:
  - pc=32'hFFFF_FFFC with not-taken exec_done → next fetch at 0.
  - rst asserted while imem_req=1 → imem_req=0 the next cycle; state returns to RESET_WAIT.
